// File: rtl/rbz_tex_fetch_pkg.sv
// Shared definitions for the rbzero texture-flash fetch unit: state
// encoding, default transaction constants and texel geometry.
package rbz_tex_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } state_e;

  // Default Fast Read Quad Output transaction shape.
  localparam logic [7:0] OPCODE_DEF     = 8'h6B;
  localparam int         ADDR_W_DEF     = 24;
  localparam int         DUMMY_CLKS_DEF = 8;

  // Fixed phase lengths, in SCLK periods.
  localparam int CMD_CLKS  = 8;
  localparam int DATA_CLKS = 2;

  // Texel is {BbGgRr}, delivered as two 3-bit nibbles on io[2:0].
  localparam int TEXEL_W = 6;
  localparam int NIB_W   = TEXEL_W / 2;

  // Per-phase SCLK period counter width.
  localparam int CNT_W = 6;

endpackage : rbz_tex_pkg

// File: rtl/rbz_tex_fetch_if.sv
// Request/response handshake between the texture-address generator
// (master) and the flash fetch unit (slave).
interface rbz_tex_fetch_if #(
  parameter int ADDR_W = 24
);
  import rbz_tex_pkg::*;

  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic               o_busy;
  logic               o_valid;
  logic [TEXEL_W-1:0] o_texel;

  modport master (
    output i_req,
    output i_addr,
    input  o_busy,
    input  o_valid,
    input  o_texel
  );

  modport slave (
    input  i_req,
    input  i_addr,
    output o_busy,
    output o_valid,
    output o_texel
  );

endinterface : rbz_tex_fetch_if

// File: rtl/rbz_tex_fetch.sv
// SPI flash texel fetcher. Each accepted request runs one Fast Read Quad
// Output transaction (opcode + address on io0, dummy clocks, then two
// nibbles on io[2:0]) and returns a 6-bit texel with a one-cycle valid.
// SCLK runs at clk/2: phase 0 drives sclk low, phase 1 drives it high.
module rbz_tex_fetch
  import rbz_tex_pkg::*;
#(
  parameter logic [7:0] OPCODE     = OPCODE_DEF,
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter int         DUMMY_CLKS = DUMMY_CLKS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  rbz_tex_fetch_if.slave bus,
  output logic           o_tex_csb,
  output logic           o_tex_sclk,
  output logic           o_tex_out0,
  output logic           o_tex_oeb0,
  input  logic [3:0]     i_tex_in
);

  localparam int SHIFT_W = 8 + ADDR_W;

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CLKS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CLKS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_CLKS - 1);

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [NIB_W-1:0]     nib_q, nib_d;
  logic [TEXEL_W-1:0]   texel_q, texel_d;

  logic [CNT_W-1:0]     last_cnt;
  state_e               next_state;
  logic                 sclk_active;
  logic                 io0_drive;

  // io3 is not wired on the board; the pad value is deliberately dropped.
  logic unused_io3;
  assign unused_io3 = i_tex_in[3];

  // Length of the current phase and the state that follows it.
  always_comb begin
    last_cnt   = '0;
    next_state = IDLE;
    case (state_q)
      CMD:     begin last_cnt = CMD_LAST;   next_state = ADDR;  end
      ADDR:    begin last_cnt = ADDR_LAST;  next_state = DUMMY; end
      DUMMY:   begin last_cnt = DUMMY_LAST; next_state = DATA;  end
      DATA:    begin last_cnt = DATA_LAST;  next_state = DONE;  end
      default: begin last_cnt = '0;         next_state = IDLE;  end
    endcase
  end

  // Next-state logic: accept, SCLK phase toggling, per-phase period count,
  // io0 shift on each period end, and nibble capture at the end of phase 1.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; an unassigned path in always_comb infers a latch.
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    nib_d   = nib_q;
    texel_d = texel_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          state_d = CMD;
          phase_d = 1'b0;
          cnt_d   = '0;
          shift_d = {OPCODE, bus.i_addr};
        end
      end

      CMD, ADDR, DUMMY, DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          // End of an SCLK period: io0 moves on at the start of the next
          // phase 0, so the flash sees a stable bit on the rising edge.
          if (state_q == CMD || state_q == ADDR) begin
            shift_d = shift_q << 1;
          end
          if (state_q == DATA) begin
            if (cnt_q == '0) begin
              nib_d = i_tex_in[NIB_W-1:0];
            end else begin
              texel_d = {nib_q, i_tex_in[NIB_W-1:0]};
            end
          end
          if (cnt_q == last_cnt) begin
            state_d = next_state;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        phase_d = 1'b0;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset; a partial texel in
  // nib_q is never exposed because texel_q only loads on the final nibble.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      nib_q   <= '0;
      texel_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      nib_q   <= nib_d;
      texel_q <= texel_d;
    end
  end

  // Pin and handshake decode from registered state only.
  assign sclk_active = (state_q == CMD) || (state_q == ADDR) ||
                       (state_q == DUMMY) || (state_q == DATA);
  assign io0_drive   = (state_q == CMD) || (state_q == ADDR);

  assign o_tex_csb   = ~sclk_active;
  assign o_tex_sclk  = sclk_active & phase_q;
  assign o_tex_out0  = io0_drive & shift_q[SHIFT_W-1];
  assign o_tex_oeb0  = ~io0_drive;

  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_texel = texel_q;

endmodule : rbz_tex_fetch

// File: tb/tb_rbz_tex_fetch.sv
// Self-checking bench for rbz_tex_fetch: a behavioural flash model that
// counts SCLK rising edges and serves two nibbles, a pin monitor that
// accumulates per-transaction statistics, a vector table of fetches and
// hand-written sequences for busy, mid-transaction reset and back-to-back.
module tb_rbz_tex_fetch;

  localparam logic [7:0] OPC     = 8'h6B;
  localparam int         LAT     = 85;   // accept cycle -> valid cycle
  localparam int         PERIOD  = 86;   // back-to-back fetch period
  localparam int         CSB_LOW = 84;
  localparam int         RISES   = 42;
  localparam int         OEB_LOW = 64;   // (8 + 24) SCLK periods * 2

  logic        clk;
  logic        rst_n;
  logic        tex_csb, tex_sclk, tex_out0, tex_oeb0;
  logic [3:0]  tex_in;

  rbz_tex_fetch_if #(.ADDR_W(24)) bus ();

  rbz_tex_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_tex_csb  (tex_csb),
    .o_tex_sclk (tex_sclk),
    .o_tex_out0 (tex_out0),
    .o_tex_oeb0 (tex_oeb0),
    .i_tex_in   (tex_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- flash model and pin monitor ----------------
  logic [2:0] fl_n0, fl_n1;
  logic       fl_io3_0, fl_io3_1;
  int         fl_rise = 0;
  logic       sclk_prev = 1'b0;

  int          csb_low_total = 0;
  int          oeb_low_total = 0;
  int          rise_total    = 0;
  int          valid_total   = 0;
  logic [63:0] io0_hist      = '0;

  always @(negedge clk) begin
    logic rise;
    rise = tex_sclk && !sclk_prev;
    sclk_prev = tex_sclk;
    if (!tex_csb) csb_low_total++;
    if (!tex_oeb0) oeb_low_total++;
    if (bus.o_valid) valid_total++;
    if (rise) begin
      rise_total++;
      if (!tex_oeb0) io0_hist = {io0_hist[62:0], tex_out0};
    end
    // Flash: 8 cmd + 24 addr + 8 dummy rising edges, then one nibble per
    // rising edge, held while SCLK is high. Anything else is noise.
    if (tex_csb) fl_rise = 0;
    else if (rise) fl_rise++;
    if (!tex_csb && fl_rise == 41)      tex_in = {fl_io3_0, fl_n0};
    else if (!tex_csb && fl_rise == 42) tex_in = {fl_io3_1, fl_n1};
    else                                tex_in = 4'($urandom);
  end

  // ---------------- helpers ----------------
  function automatic logic [5:0] ref_texel(input logic [2:0] n0, input logic [2:0] n1);
    return 6'(int'(n0) * 8 + int'(n1));
  endfunction

  task automatic wait_valid(input int budget, output bit found, output int at);
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        found = 1'b1;
        at    = cyc;
        break;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One complete fetch starting at the current negedge (DUT idle).
  task automatic do_fetch(input string tag, input logic [23:0] a,
                          input logic [2:0] n0, input logic [2:0] n1,
                          input logic io3_0, input logic io3_1,
                          input logic [5:0] exp_texel);
    int s_csb, s_oeb, s_rise, s_valid, n, at;
    bit found;
    fl_n0 = n0; fl_n1 = n1; fl_io3_0 = io3_0; fl_io3_1 = io3_1;
    s_csb = csb_low_total; s_oeb = oeb_low_total;
    s_rise = rise_total;   s_valid = valid_total;
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    n = cyc;
    @(negedge clk);
    bus.i_req  = 1'b0;
    bus.i_addr = 24'($urandom);
    wait_valid(200, found, at);
    check({tag, " valid seen"}, 64'(found), 64'd1);
    check({tag, " latency"}, 64'(at - n), 64'(LAT));
    check({tag, " texel"}, 64'(bus.o_texel), 64'(exp_texel));
    @(negedge clk);
    check({tag, " opcode on io0"}, 64'(io0_hist[31:24]), 64'(OPC));
    check({tag, " addr on io0"}, 64'(io0_hist[23:0]), 64'(a));
    check({tag, " csb low cycles"}, 64'(csb_low_total - s_csb), 64'(CSB_LOW));
    check({tag, " sclk rises"}, 64'(rise_total - s_rise), 64'(RISES));
    check({tag, " oeb0 low cycles"}, 64'(oeb_low_total - s_oeb), 64'(OEB_LOW));
    check({tag, " valid pulses"}, 64'(valid_total - s_valid), 64'd1);
    check({tag, " texel held"}, 64'(bus.o_texel), 64'(exp_texel));
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [2:0]  n0;
    logic [2:0]  n1;
    logic        io3_0;
    logic        io3_1;
    logic [5:0]  exp_texel;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, at, at2, at3, s_valid;
    bit found;

    // Vector table: flash returns 4'hD then 4'h3 for the reference fetch.
    tbl[0] = '{24'h123456, 3'b101, 3'b011, 1'b1, 1'b0, 6'b101_011};
    tbl[1] = '{24'h123456, 3'b101, 3'b011, 1'b1, 1'b1, 6'b101_011};
    for (int i = 2; i < 6; i++) begin
      tbl[i].addr  = 24'($urandom);
      tbl[i].n0    = 3'($urandom);
      tbl[i].n1    = 3'($urandom);
      tbl[i].io3_0 = 1'($urandom);
      tbl[i].io3_1 = 1'($urandom);
      tbl[i].exp_texel = ref_texel(tbl[i].n0, tbl[i].n1);
    end
    tbl[5].addr = 24'hFFFFFF;
    tbl[4].addr = 24'h000000;

    fl_n0 = '0; fl_n1 = '0; fl_io3_0 = 1'b0; fl_io3_1 = 1'b0;
    tex_in = '0;

    // ---- reset with i_req held high ----
    rst_n      = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 24'hABCDEF;
    repeat (3) @(negedge clk);
    check("reset csb", 64'(tex_csb), 64'd1);
    check("reset sclk", 64'(tex_sclk), 64'd0);
    check("reset out0", 64'(tex_out0), 64'd0);
    check("reset oeb0", 64'(tex_oeb0), 64'd1);
    check("reset busy", 64'(bus.o_busy), 64'd0);
    check("reset valid", 64'(bus.o_valid), 64'd0);
    check("reset texel", 64'(bus.o_texel), 64'd0);
    bus.i_req = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("post-reset idle busy", 64'(bus.o_busy), 64'd0);
    check("post-reset idle csb", 64'(tex_csb), 64'd1);

    // ---- table-driven fetches ----
    for (int i = 0; i < 6; i++) begin
      do_fetch($sformatf("vec%0d", i), tbl[i].addr, tbl[i].n0, tbl[i].n1,
               tbl[i].io3_0, tbl[i].io3_1, tbl[i].exp_texel);
    end

    // ---- request while busy is ignored; next accept at N+86 ----
    fl_n0 = 3'b010; fl_n1 = 3'b111; fl_io3_0 = 1'b0; fl_io3_1 = 1'b1;
    s_valid = valid_total;
    bus.i_req  = 1'b1;
    bus.i_addr = 24'h0F0F0F;
    n = cyc;
    @(negedge clk);
    bus.i_req = 1'b0;
    wait_until(n + 20);
    bus.i_req  = 1'b1;
    bus.i_addr = 24'hEEEEEE;
    @(negedge clk);
    bus.i_req = 1'b0;
    wait_valid(200, found, at);
    check("busy-req valid seen", 64'(found), 64'd1);
    check("busy-req latency", 64'(at - n), 64'(LAT));
    check("busy-req texel", 64'(bus.o_texel), 64'(ref_texel(3'b010, 3'b111)));
    bus.i_req  = 1'b1;             // raised in DONE: must not be taken here
    bus.i_addr = 24'h00ABCD;
    @(negedge clk);
    check("busy-req idle at N+86", 64'(bus.o_busy), 64'd0);
    check("busy-req addr on io0", 64'(io0_hist[23:0]), 64'h0F0F0F);
    check("busy-req single valid", 64'(valid_total - s_valid), 64'd1);
    @(negedge clk);
    bus.i_req = 1'b0;
    check("busy-req accept N+86", 64'(bus.o_busy), 64'd1);
    wait_valid(200, found, at2);
    check("busy-req second latency", 64'(at2 - at), 64'(PERIOD));
    @(negedge clk);
    check("busy-req second addr", 64'(io0_hist[23:0]), 64'h00ABCD);

    // ---- reset in the middle of ADDR ----
    fl_n0 = 3'b110; fl_n1 = 3'b001; fl_io3_0 = 1'b1; fl_io3_1 = 1'b0;
    s_valid = valid_total;
    bus.i_req  = 1'b1;
    bus.i_addr = 24'h5A5A5A;
    n = cyc;
    @(negedge clk);
    bus.i_req = 1'b0;
    wait_until(n + 30);
    check("mid-addr csb low before reset", 64'(tex_csb), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-reset csb", 64'(tex_csb), 64'd1);
    check("mid-reset sclk", 64'(tex_sclk), 64'd0);
    check("mid-reset oeb0", 64'(tex_oeb0), 64'd1);
    check("mid-reset busy", 64'(bus.o_busy), 64'd0);
    check("mid-reset texel", 64'(bus.o_texel), 64'd0);
    wait_until(n + 35);
    check("mid-reset no valid", 64'(valid_total - s_valid), 64'd0);
    bus.i_req  = 1'b1;
    bus.i_addr = 24'h3C3C3C;
    n = cyc;
    @(negedge clk);
    bus.i_req = 1'b0;
    wait_valid(200, found, at);
    check("post-reset fetch latency", 64'(at - n), 64'(LAT));
    check("post-reset fetch texel", 64'(bus.o_texel), 64'(ref_texel(3'b110, 3'b001)));
    @(negedge clk);
    check("post-reset fetch addr", 64'(io0_hist[23:0]), 64'h3C3C3C);

    // ---- back-to-back with i_req held high ----
    fl_n0 = 3'b011; fl_n1 = 3'b100; fl_io3_0 = 1'b1; fl_io3_1 = 1'b1;
    bus.i_req  = 1'b1;
    bus.i_addr = 24'h777777;
    wait_valid(200, found, at);
    check("b2b first valid", 64'(found), 64'd1);
    wait_valid(200, found, at2);
    check("b2b period 1", 64'(at2 - at), 64'(PERIOD));
    check("b2b csb high in DONE", 64'(tex_csb), 64'd1);
    @(negedge clk);
    check("b2b csb high in accept", 64'(tex_csb), 64'd1);
    check("b2b idle in accept", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    check("b2b csb low after accept", 64'(tex_csb), 64'd0);
    wait_valid(200, found, at3);
    check("b2b period 2", 64'(at3 - at2), 64'(PERIOD));
    check("b2b texel", 64'(bus.o_texel), 64'(ref_texel(3'b011, 3'b100)));
    bus.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b stops when req drops", 64'(bus.o_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rbz_tex_fetch
